// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and its forwarding unit.
// The load MemToReg encoding is also used by the decode control unit.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

    // The M stage holds the younger result, so it wins over W. $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wr_m,
        input logic [4:0] dst_m,
        input logic       wr_w,
        input logic [4:0] dst_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (dst_m != 5'd0) && (dst_m == src)) begin
            sel = FWD_M;
        end else if (wr_w && (dst_w != 5'd0) && (dst_w == src)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding selects for rs and rt; purely combinational.
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs_E,
    input  logic [4:0] rt_E,
    input  logic [4:0] WriteReg_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E
);

    always_comb begin
        ForwardA_E = fwd_sel(rs_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
        ForwardB_E = fwd_sel(rt_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: memory-wait FSM with timeout, load-use stall,
// control flush, forwarding selects and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [1:0] LOAD_SEL    = MEMTOREG_LOAD,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       rs_E,
    input  logic [4:0]       rt_E,
    input  logic [4:0]       WriteReg_E,
    input  logic [4:0]       WriteReg_M,
    input  logic [4:0]       WriteReg_W,
    input  logic             RegWrite_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic [1:0]       MemToReg_E,
    input  logic             BranchTaken_D,
    input  logic             Jump_D,
    input  logic             MemReq_M,
    input  logic             MemReady,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [1:0]       o_dbg_state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         r_state;
    hz_state_t         w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_next_wait;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic              w_mem_stall;
    logic              w_load_use;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    forward_unit u_forward_unit (
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .WriteReg_M (WriteReg_M),
        .WriteReg_W (WriteReg_W),
        .RegWrite_M (RegWrite_M),
        .RegWrite_W (RegWrite_W),
        .ForwardA_E (w_fwd_a),
        .ForwardB_E (w_fwd_b)
    );

    // The first miss cycle stalls straight from RUN so there is no one-cycle lag.
    always_comb begin
        w_mem_stall = (r_state != RUN) || (MemReq_M && !MemReady);
        w_load_use  = RegWrite_E && (MemToReg_E == LOAD_SEL) && (WriteReg_E != 5'd0)
                      && ((WriteReg_E == rs_D) || (WriteReg_E == rt_D));
    end

    always_comb begin
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Stall_M    = 1'b0;
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        if (!reset) begin
            ForwardA_E = w_fwd_a;
            ForwardB_E = w_fwd_b;
            if (w_mem_stall) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
            end else if (w_load_use) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end else if (BranchTaken_D || Jump_D) begin
                Flush_D = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (MemReq_M && !MemReady) begin
                    w_next_state = MEM_WAIT;
                    w_next_wait  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReady) begin
                    w_next_state = RUN;
                    w_next_wait  = '0;
                end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    w_next_state = ERROR;
                end else begin
                    w_next_wait = r_wait_cnt + 1'b1;
                end
            end
            ERROR: begin
                w_next_state = ERROR;
            end
            default: begin
                w_next_state = RUN;
                w_next_wait  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
            r_mem_err  <= r_mem_err || (w_next_state == ERROR);
            if (Stall_F && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign MemErr      = r_mem_err;
    assign StallCycles = r_stall_cycles;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, forwarding, memory wait,
// timeout to ERROR, async reset and flush priority.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D, rs_E, rt_E;
    logic [4:0]  WriteReg_E, WriteReg_M, WriteReg_W;
    logic        RegWrite_E, RegWrite_M, RegWrite_W;
    logic [1:0]  MemToReg_E;
    logic        BranchTaken_D, Jump_D, MemReq_M, MemReady;
    logic        Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        MemErr;
    logic [15:0] StallCycles;
    logic [1:0]  o_dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemToReg_E(MemToReg_E), .BranchTaken_D(BranchTaken_D), .Jump_D(Jump_D),
        .MemReq_M(MemReq_M), .MemReady(MemReady),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .MemErr(MemErr), .StallCycles(StallCycles), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
        WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
        RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        MemToReg_E = 2'b00; BranchTaken_D = 0; Jump_D = 0;
        MemReq_M = 0; MemReady = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
    endtask

    function automatic logic [3:0] stalls();
        return {Stall_F, Stall_D, Stall_E, Stall_M};
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b1;
        // Hazardous inputs during reset must not leak to the outputs.
        RegWrite_E = 1; MemToReg_E = 2'b01; WriteReg_E = 5'd8; rs_D = 5'd8;
        RegWrite_M = 1; WriteReg_M = 5'd3; rs_E = 5'd3; MemReq_M = 1; Jump_D = 1;
        tick();
        tick();
        chk("rst_stalls", {28'd0, stalls()}, 32'h0);
        chk("rst_flush", {Flush_D, Flush_E}, 0);
        chk("rst_fwd_a", ForwardA_E, 2'b00);
        chk("rst_memerr", MemErr, 0);
        chk("rst_cnt", StallCycles, 0);
        chk("rst_state", o_dbg_state, 2'd0);
        clear_inputs();
        reset = 1'b0;
        settle();

        // Load-use with a taken branch: the stall wins.
        RegWrite_E = 1; MemToReg_E = 2'b01; WriteReg_E = 5'd8; rs_D = 5'd8;
        BranchTaken_D = 1;
        settle();
        chk("lu_stall_fd", {Stall_F, Stall_D}, 2'b11);
        chk("lu_stall_em", {Stall_E, Stall_M}, 2'b00);
        chk("lu_flush_e", Flush_E, 1);
        chk("lu_flush_d", Flush_D, 0);
        tick();
        // Load moves to M; branch re-resolves.
        RegWrite_E = 0; MemToReg_E = 2'b00; WriteReg_E = 0;
        RegWrite_M = 1; WriteReg_M = 5'd8; rs_E = 5'd8;
        settle();
        chk("lu2_stall", {28'd0, stalls()}, 32'h0);
        chk("lu2_flush", {Flush_D, Flush_E}, 2'b10);
        chk("lu2_cnt", StallCycles, 1);
        chk("lu2_fwd_a", ForwardA_E, 2'b10);

        // Load-use boundaries: destination $0, non-load, rt match.
        clear_inputs();
        RegWrite_E = 1; MemToReg_E = 2'b01; WriteReg_E = 5'd0; rs_D = 5'd0;
        settle();
        chk("lu_r0", Stall_F, 0);
        WriteReg_E = 5'd9; rt_D = 5'd9; MemToReg_E = 2'b00;
        settle();
        chk("lu_notload", Stall_F, 0);
        MemToReg_E = 2'b01;
        settle();
        chk("lu_rt", {Stall_F, Flush_E}, 2'b11);
        Jump_D = 1; RegWrite_E = 0;
        settle();
        chk("jump_flush", {Flush_D, Stall_F}, 2'b10);

        // Forwarding.
        clear_inputs();
        RegWrite_M = 1; WriteReg_M = 5'd5; RegWrite_W = 1; WriteReg_W = 5'd5; rs_E = 5'd5;
        settle();
        chk("fwd_a_m", ForwardA_E, 2'b10);
        WriteReg_M = 5'd0;
        settle();
        chk("fwd_a_w", ForwardA_E, 2'b01);
        rt_E = 5'd0;
        settle();
        chk("fwd_b_r0", ForwardB_E, 2'b00);
        rt_E = 5'd5; WriteReg_M = 5'd5; RegWrite_M = 0;
        settle();
        chk("fwd_b_w", ForwardB_E, 2'b01);
        RegWrite_W = 0;
        settle();
        chk("fwd_b_rf", ForwardB_E, 2'b00);

        // Memory wait: ready low 3 cycles then high.
        clear_inputs();
        pulse_reset();
        chk("mw_cnt0", StallCycles, 0);
        exp_q.push_back(4'hF); exp_q.push_back(4'hF);
        exp_q.push_back(4'hF); exp_q.push_back(4'hF);
        exp_q.push_back(4'h0);
        MemReq_M = 1; MemReady = 0; BranchTaken_D = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) MemReady = 1;
            if (i == 4) begin MemReq_M = 0; MemReady = 0; end
            settle();
            chk($sformatf("mw_stall%0d", i), stalls(), exp_q.pop_front());
            chk($sformatf("mw_flushd%0d", i), Flush_D, (i == 4) ? 1 : 0);
            tick();
        end
        BranchTaken_D = 0;
        chk("mw_state", o_dbg_state, 2'd0);
        chk("mw_memerr", MemErr, 0);
        chk("mw_cnt", StallCycles, 4);

        // Timeout: ready low for 20 cycles.
        clear_inputs();
        pulse_reset();
        MemReq_M = 1; MemReady = 0;
        for (int k = 0; k < 20; k++) begin
            settle();
            chk($sformatf("to_stall%0d", k), stalls(), 4'hF);
            if (k == 15) chk("to_err_pre", MemErr, 0);
            if (k == 16) chk("to_err_set", MemErr, 1);
            if (k == 16) chk("to_state", o_dbg_state, 2'd2);
            tick();
        end
        MemReq_M = 0; MemReady = 1;
        settle();
        chk("to_sticky", MemErr, 1);
        chk("to_hold", stalls(), 4'hF);
        chk("to_cnt", StallCycles, 20);

        // Asynchronous reset away from the clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_memerr", MemErr, 0);
        chk("ar_stalls", stalls(), 4'h0);
        chk("ar_cnt", StallCycles, 0);
        chk("ar_state", o_dbg_state, 2'd0);
        tick();
        reset = 1'b0;
        clear_inputs();
        settle();
        tick();
        chk("post_rst", {stalls(), MemErr}, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
